// File: rtl/fp_int_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fp_int_wb_arbiter
// Description : Round-robin arbiter that shares the single FP-to-integer
//               writeback port among NUM_SRC FP units (compare/classify/
//               move/convert, div/sqrt status path, ...). The winning result
//               is captured into one registered output slot together with its
//               instruction id and accrued fflags. Back-pressure comes from
//               wb_ack; an acked slot can be refilled in the same cycle, so
//               the port sustains one result per cycle.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   NUM_SRC    number of requesting FP units (>= 2)
//   ID_W       instruction id width
//   XLEN       result data width
// Ports
//   clk         in   clock
//   rst         in   synchronous active-high reset
//   src_done    in   [NUM_SRC]        source i holds a valid result
//   src_id      in   [NUM_SRC*ID_W]   packed ids, source i at [i*ID_W +: ID_W]
//   src_rd      in   [NUM_SRC*XLEN]   packed results
//   src_fflags  in   [NUM_SRC*5]      packed flags {nv,dz,of,uf,nx}
//   src_ack     out  [NUM_SRC]        one-hot grant, source consumes this cycle
//   wb_done     out                   output slot valid
//   wb_id       out  [ID_W]           id of slot contents
//   wb_rd       out  [XLEN]           result of slot contents
//   wb_fflags   out  [5]              flags of slot contents
//   wb_ack      in                    downstream consumed the slot this cycle
// ============================================================================
module fp_int_wb_arbiter #(
   parameter int NUM_SRC = 2,
   parameter int ID_W    = 3,
   parameter int XLEN    = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_SRC-1:0]      src_done,
   input  logic [NUM_SRC*ID_W-1:0] src_id,
   input  logic [NUM_SRC*XLEN-1:0] src_rd,
   input  logic [NUM_SRC*5-1:0]    src_fflags,
   output logic [NUM_SRC-1:0]      src_ack,
   output logic                    wb_done,
   output logic [ID_W-1:0]         wb_id,
   output logic [XLEN-1:0]         wb_rd,
   output logic [4:0]              wb_fflags,
   input  logic                    wb_ack
);

   localparam int c_PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
   localparam int c_FF_W  = 5;

   // ------------------------------------------------------------------------
   // Registered state
   // ------------------------------------------------------------------------
   logic [c_PTR_W-1:0] r_ptr;        // highest-priority source for next grant
   logic               r_wb_done;
   logic [ID_W-1:0]    r_wb_id;
   logic [XLEN-1:0]    r_wb_rd;
   logic [c_FF_W-1:0]  r_wb_fflags;

   // ------------------------------------------------------------------------
   // Combinational signals
   // ------------------------------------------------------------------------
   logic               w_advance;    // slot can accept a new entry this cycle
   logic               w_any_req;
   logic               w_grant;      // a grant is issued this cycle
   logic [NUM_SRC-1:0] w_mask;       // sources at or above the pointer
   logic [NUM_SRC-1:0] w_req_hi;     // requests in the upper (first) window
   logic [NUM_SRC-1:0] w_cand;       // window searched for the lowest index
   logic [NUM_SRC-1:0] w_sel;        // one-hot winner, independent of advance
   logic [c_PTR_W-1:0] w_sel_idx;
   logic [c_PTR_W-1:0] w_ptr_nxt;
   logic [ID_W-1:0]    w_sel_id;
   logic [XLEN-1:0]    w_sel_rd;
   logic [c_FF_W-1:0]  w_sel_fflags;

   assign w_advance = ~r_wb_done | wb_ack;
   assign w_any_req = |src_done;
   assign w_grant   = w_advance & w_any_req & ~rst;

   // ------------------------------------------------------------------------
   // Round-robin search. The rotated search order ptr..N-1, 0..ptr-1 is
   // realised as two windows: requests at index >= ptr are tried first; only
   // if that window is empty does the lowest requesting index overall win,
   // which is exactly the wrapped part of the order.
   // ------------------------------------------------------------------------
   always_comb begin
      w_mask = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         w_mask[i] = (c_PTR_W'(i) >= r_ptr);
      end
   end

   assign w_req_hi = src_done & w_mask;
   assign w_cand   = (|w_req_hi) ? w_req_hi : src_done;

   always_comb begin : p_pick
      logic v_found;
      v_found   = 1'b0;
      w_sel     = '0;
      w_sel_idx = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (!v_found && w_cand[i]) begin
            v_found   = 1'b1;
            w_sel[i]  = 1'b1;
            w_sel_idx = c_PTR_W'(i);
         end
      end
   end

   // Pointer moves just past the winner, wrapping after the last source.
   assign w_ptr_nxt = (w_sel_idx == c_PTR_W'(NUM_SRC - 1)) ? '0
                                                           : w_sel_idx + c_PTR_W'(1);

   // ------------------------------------------------------------------------
   // Payload mux: AND-OR over the one-hot winner avoids a variable-width
   // part select on the packed source buses.
   // ------------------------------------------------------------------------
   always_comb begin
      w_sel_id     = '0;
      w_sel_rd     = '0;
      w_sel_fflags = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (w_sel[i]) begin
            w_sel_id     = w_sel_id     | src_id[i*ID_W +: ID_W];
            w_sel_rd     = w_sel_rd     | src_rd[i*XLEN +: XLEN];
            w_sel_fflags = w_sel_fflags | src_fflags[i*c_FF_W +: c_FF_W];
         end
      end
   end

   // The ack is gated by rst so no source drops its result into a slot that
   // reset is about to discard.
   assign src_ack = w_grant ? w_sel : '0;

   // ------------------------------------------------------------------------
   // Output slot and pointer
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr       <= '0;
         r_wb_done   <= 1'b0;
         r_wb_id     <= '0;
         r_wb_rd     <= '0;
         r_wb_fflags <= '0;
      end else if (w_advance) begin
         if (w_grant) begin
            // Covers both an empty slot and an ack+refill in the same edge.
            r_wb_done   <= 1'b1;
            r_wb_id     <= w_sel_id;
            r_wb_rd     <= w_sel_rd;
            r_wb_fflags <= w_sel_fflags;
            r_ptr       <= w_ptr_nxt;
         end else begin
            // Slot drained with nothing to replace it; payload left as is.
            r_wb_done   <= 1'b0;
         end
      end
   end

   assign wb_done   = r_wb_done;
   assign wb_id     = r_wb_id;
   assign wb_rd     = r_wb_rd;
   assign wb_fflags = r_wb_fflags;

endmodule
`default_nettype wire

// File: tb/tb_fp_int_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_int_wb_arbiter
// Description : Self-checking bench for fp_int_wb_arbiter. A NUM_SRC=2
//               instance is tracked by a reference model and a scoreboard
//               queue of expected slot contents; a NUM_SRC=3 instance is
//               exercised for pointer wrap-around with source skipping.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_int_wb_arbiter;

   logic clk;
   logic rst;

   // NUM_SRC=2 instance
   logic [1:0]  src_done;
   logic [5:0]  src_id;
   logic [63:0] src_rd;
   logic [9:0]  src_fflags;
   logic [1:0]  src_ack;
   logic        wb_done;
   logic [2:0]  wb_id;
   logic [31:0] wb_rd;
   logic [4:0]  wb_fflags;
   logic        wb_ack;

   // NUM_SRC=3 instance
   logic [2:0]  d3_done;
   logic [8:0]  d3_id;
   logic [95:0] d3_rd;
   logic [14:0] d3_ff;
   logic [2:0]  d3_ack;
   logic        d3_wb_done;
   logic [2:0]  d3_wb_id;
   logic [31:0] d3_wb_rd;
   logic [4:0]  d3_wb_ff;
   logic        d3_wb_ack;

   int checks   = 0;
   int failures = 0;

   fp_int_wb_arbiter #(.NUM_SRC(2), .ID_W(3), .XLEN(32)) u_dut2 (
      .clk(clk), .rst(rst),
      .src_done(src_done), .src_id(src_id), .src_rd(src_rd), .src_fflags(src_fflags),
      .src_ack(src_ack),
      .wb_done(wb_done), .wb_id(wb_id), .wb_rd(wb_rd), .wb_fflags(wb_fflags),
      .wb_ack(wb_ack)
   );

   fp_int_wb_arbiter #(.NUM_SRC(3), .ID_W(3), .XLEN(32)) u_dut3 (
      .clk(clk), .rst(rst),
      .src_done(d3_done), .src_id(d3_id), .src_rd(d3_rd), .src_fflags(d3_ff),
      .src_ack(d3_ack),
      .wb_done(d3_wb_done), .wb_id(d3_wb_id), .wb_rd(d3_wb_rd), .wb_fflags(d3_wb_ff),
      .wb_ack(d3_wb_ack)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------------
   // Reference model + scoreboard for the NUM_SRC=2 instance, evaluated on
   // the falling edge where inputs and outputs are stable.
   // ------------------------------------------------------------------------
   typedef struct packed {
      logic [2:0]  id;
      logic [31:0] rd;
      logic [4:0]  ff;
   } ent_t;

   ent_t       q[$];
   int         m_ptr    = 0;
   logic [1:0] last_gnt = '0;

   always @(negedge clk) begin
      logic       has;
      logic       adv;
      logic [1:0] exp_ack;
      int         j;
      if (rst) begin
         check("ack_in_rst", {62'd0, src_ack}, 64'd0);
         q.delete();
         m_ptr    = 0;
         last_gnt = '0;
      end else begin
         has = (q.size() > 0);
         check("wb_done", {63'd0, wb_done}, {63'd0, has});
         if (has) begin
            check("wb_id", {61'd0, wb_id}, {61'd0, q[0].id});
            check("wb_rd", {32'd0, wb_rd}, {32'd0, q[0].rd});
            check("wb_ff", {59'd0, wb_fflags}, {59'd0, q[0].ff});
         end
         adv = !has || wb_ack;
         if (has && wb_ack) void'(q.pop_front());
         exp_ack = '0;
         if (adv) begin
            for (int k = 0; k < 2; k++) begin
               j = (m_ptr + k) % 2;
               if (exp_ack == 2'b00 && src_done[j]) begin
                  exp_ack[j] = 1'b1;
                  q.push_back('{id: src_id[j*3 +: 3], rd: src_rd[j*32 +: 32],
                                ff: src_fflags[j*5 +: 5]});
                  m_ptr = (j == 1) ? 0 : j + 1;
               end
            end
         end
         check("src_ack", {62'd0, src_ack}, {62'd0, exp_ack});
         last_gnt = exp_ack;
      end
   end

   // Advance one cycle; a source that was just acked presents a fresh result.
   task automatic cycle();
      @(posedge clk);
      #1;
      for (int j = 0; j < 2; j++) begin
         if (last_gnt[j]) begin
            src_id[j*3 +: 3]     = 3'($urandom);
            src_rd[j*32 +: 32]   = $urandom;
            src_fflags[j*5 +: 5] = 5'($urandom);
         end
      end
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   initial begin
      logic [2:0] seq[4];
      logic [2:0] pid[4];

      rst        = 1'b1;
      src_done   = '0;
      src_id     = '0;
      src_rd     = '0;
      src_fflags = '0;
      wb_ack     = 1'b0;
      d3_done    = '0;
      d3_wb_ack  = 1'b0;
      for (int i = 0; i < 3; i++) begin
         d3_id[i*3 +: 3]   = 3'(i + 1);
         d3_rd[i*32 +: 32] = 32'hA000_0000 + 32'(i);
         d3_ff[i*5 +: 5]   = 5'(i + 1);
      end
      cycles(3);
      check("rst_wb_done", {63'd0, wb_done}, 64'd0);
      check("rst_wb_rd",   {32'd0, wb_rd},   64'd0);
      check("rst_wb_id",   {61'd0, wb_id},   64'd0);
      rst = 1'b0;
      cycle();

      // Single request into an empty slot.
      src_done        = 2'b01;
      src_id[2:0]     = 3'd5;
      src_rd[31:0]    = 32'hDEADBEEF;
      src_fflags[4:0] = 5'b10000;
      cycle();
      check("t1_done", {63'd0, wb_done}, 64'd1);
      check("t1_id",   {61'd0, wb_id}, 64'd5);
      check("t1_rd",   {32'd0, wb_rd}, 64'hDEADBEEF);
      check("t1_ff",   {59'd0, wb_fflags}, 64'h10);

      // Drain: ack with nothing pending.
      src_done = 2'b00;
      wb_ack   = 1'b1;
      cycle();
      check("t4_drain", {63'd0, wb_done}, 64'd0);
      cycle();

      // Fairness from a fresh reset.
      rst = 1'b1;
      cycle();
      rst      = 1'b0;
      src_done = 2'b11;
      wb_ack   = 1'b1;
      cycles(8);

      // Back-pressure: full slot, no ack for 3 cycles, then one ack.
      wb_ack = 1'b0;
      cycles(3);
      wb_ack = 1'b1;
      cycle();
      wb_ack = 1'b0;
      cycles(2);

      // Drain with both idle.
      src_done = 2'b00;
      wb_ack   = 1'b1;
      cycles(2);

      // Reset mid-operation with ptr=1 and a full slot.
      src_done = 2'b01;
      cycle();
      src_done = 2'b11;
      wb_ack   = 1'b0;
      rst      = 1'b1;
      cycle();
      check("t5_done", {63'd0, wb_done}, 64'd0);
      check("t5_rd",   {32'd0, wb_rd},   64'd0);
      rst = 1'b0;
      cycles(3);
      wb_ack = 1'b1;
      cycles(3);

      // Random traffic.
      for (int i = 0; i < 200; i++) begin
         src_done = src_done | 2'($urandom);
         if (last_gnt[0] && ($urandom_range(0, 1) == 0)) src_done[0] = 1'b0;
         if (last_gnt[1] && ($urandom_range(0, 1) == 0)) src_done[1] = 1'b0;
         wb_ack = 1'($urandom);
         cycle();
      end
      src_done = 2'b00;
      wb_ack   = 1'b1;
      cycles(2);

      // NUM_SRC=3: move ptr to 2, then sources 0 and 2 alternate.
      d3_wb_ack = 1'b1;
      d3_done   = 3'b010;
      @(negedge clk);
      check("t6_pre_ack", {61'd0, d3_ack}, 64'h2);
      cycle();
      d3_done = 3'b101;
      seq[0] = 3'b100; seq[1] = 3'b001; seq[2] = 3'b100; seq[3] = 3'b001;
      pid[0] = 3'd2;   pid[1] = 3'd3;   pid[2] = 3'd1;   pid[3] = 3'd3;
      for (int n = 0; n < 4; n++) begin
         @(negedge clk);
         check("t6_ack",   {61'd0, d3_ack},   {61'd0, seq[n]});
         check("t6_done",  {63'd0, d3_wb_done}, 64'd1);
         check("t6_wb_id", {61'd0, d3_wb_id}, {61'd0, pid[n]});
         cycle();
      end
      check("t6_last_id", {61'd0, d3_wb_id}, 64'd1);
      check("t6_last_rd", {32'd0, d3_wb_rd}, 64'hA000_0000);
      d3_done = 3'b000;
      cycles(2);
      check("t6_drain", {63'd0, d3_wb_done}, 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
